// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
//   Shared types and constants for the RTC preset/enable path.
//   - rtc_time_t : packed 44-bit calendar/time word, MSB first:
//                  sec6, min6, hour6, mode2, dow3, dom5, month4, year12
//   - state_t    : sequencer states of rtc_preset_ctrl
//   - default restore time in 24 h and 12 h flavours
//   - error codes reported alongside an err pulse
//   - max_day()  : number of days in a month, with the 2100 non-leap rule
// -----------------------------------------------------------------------------
package rtc_pkg;

    typedef struct packed {
        logic [5:0]  sec;
        logic [5:0]  min;
        logic [5:0]  hour;
        logic [1:0]  mode;   // mode[0] = 12 h format
        logic [2:0]  dow;
        logic [4:0]  dom;
        logic [3:0]  month;
        logic [11:0] year;
    } rtc_time_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        LOAD    = 3'd2,
        CONFIRM = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int unsigned YEAR_MIN_DEF = 2000;
    localparam int unsigned YEAR_MAX_DEF = 2199;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_FIELD    = 2'b01;
    localparam logic [1:0] ERR_READBACK = 2'b10;

    // Value the counter takes on a restore-default load, 24 h format.
    localparam rtc_time_t DEFAULT_TIME_24 = '{
        sec:   6'd0,
        min:   6'd0,
        hour:  6'd0,
        mode:  2'b00,
        dow:   3'd1,
        dom:   5'd1,
        month: 4'd1,
        year:  12'd2000
    };

    // Same instant in 12 h format: midnight reads as 12 o'clock.
    localparam rtc_time_t DEFAULT_TIME_12 = '{
        sec:   6'd0,
        min:   6'd0,
        hour:  6'd12,
        mode:  2'b01,
        dow:   3'd1,
        dom:   5'd1,
        month: 4'd1,
        year:  12'd2000
    };

    // Days in the given month. Out-of-range months return 31; the caller
    // rejects those months on their own.
    function automatic logic [4:0] max_day(input logic [3:0]  month,
                                           input logic [11:0] year);
        logic [4:0] days;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
            4'd2: begin
                // Within the supported year range, 2100 is the only
                // multiple of four that is not a leap year.
                if ((year[1:0] == 2'b00) && (year != 12'd2100)) begin
                    days = 5'd29;
                end else begin
                    days = 5'd28;
                end
            end
            default: days = 5'd31;
        endcase
        return days;
    endfunction

endpackage

// File: rtl/rtc_time_validator.sv
// -----------------------------------------------------------------------------
// rtc_time_validator
//   Purely combinational check that a calendar/time word describes a real
//   instant in the supported year range. Shared with the register block.
//
//   Parameters
//     YEAR_MIN / YEAR_MAX : inclusive accepted year range
//   Ports
//     tm    in  rtc_time_t  candidate time word
//     valid out 1           all fields in range
// -----------------------------------------------------------------------------
module rtc_time_validator
    import rtc_pkg::*;
#(
    parameter int unsigned YEAR_MIN = YEAR_MIN_DEF,
    parameter int unsigned YEAR_MAX = YEAR_MAX_DEF
) (
    input  rtc_time_t tm,
    output logic      valid
);

    localparam logic [11:0] YMIN = 12'(YEAR_MIN);
    localparam logic [11:0] YMAX = 12'(YEAR_MAX);

    logic sec_ok;
    logic min_ok;
    logic hour_ok;
    logic dow_ok;
    logic month_ok;
    logic dom_ok;
    logic year_ok;

    always_comb begin
        sec_ok   = (tm.sec <= 6'd59);
        min_ok   = (tm.min <= 6'd59);

        // 12 h format counts 1..12; 24 h format counts 0..23 and must not
        // carry the upper mode bit.
        if (tm.mode[0]) begin
            hour_ok = (tm.hour >= 6'd1) && (tm.hour <= 6'd12);
        end else begin
            hour_ok = (tm.hour <= 6'd23) && !tm.mode[1];
        end

        dow_ok   = (tm.dow != 3'd0);
        month_ok = (tm.month >= 4'd1) && (tm.month <= 4'd12);
        dom_ok   = (tm.dom >= 5'd1) && (tm.dom <= max_day(tm.month, tm.year));
        year_ok  = (tm.year >= YMIN) && (tm.year <= YMAX);

        valid    = sec_ok && min_ok && hour_ok && dow_ok &&
                   month_ok && dom_ok && year_ok;
    end

endmodule

// File: rtl/rtc_preset_ctrl.sv
// -----------------------------------------------------------------------------
// rtc_preset_ctrl
//   Owns the preset/enable interface of the RTC time counter. Two requesters
//   (host register block, external time-sync unit) issue set-time or
//   restore-default commands; they are served round-robin, validated, loaded
//   into the counter, read back for confirmation and answered with a single
//   ack or err pulse.
//
//   Parameters
//     YEAR_MIN / YEAR_MAX     accepted year range for preset commands
//   Ports
//     clk_1Hz_i               1 Hz clock
//     rstn_i                  asynchronous active-low reset
//     host_req_i/sync_req_i   level request, held until ack/err
//     host_op_i/sync_op_i     0 = preset from time bus, 1 = restore default
//     host_time_i/sync_time_i requested time (rtc_time_t)
//     host_ack_o/sync_ack_o   one-cycle success pulse to the granted side
//     host_err_o/sync_err_o   one-cycle failure pulse to the granted side
//     err_code_o              01 invalid field, 10 readback mismatch
//     busy_o                  sequencer not idle
//     cnt_enable_o            counter load strobe
//     cnt_en_preset_o         counter loads cnt_time_o (else its default)
//     cnt_time_o              time presented to the counter
//     cnt_mode12_o            12 h format select to the counter
//     cur_time_i              live counter value (rtc_time_t)
// -----------------------------------------------------------------------------
module rtc_preset_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned YEAR_MIN = YEAR_MIN_DEF,
    parameter int unsigned YEAR_MAX = YEAR_MAX_DEF
) (
    input  logic       clk_1Hz_i,
    input  logic       rstn_i,

    input  logic       host_req_i,
    input  logic       host_op_i,
    input  rtc_time_t  host_time_i,
    output logic       host_ack_o,
    output logic       host_err_o,

    input  logic       sync_req_i,
    input  logic       sync_op_i,
    input  rtc_time_t  sync_time_i,
    output logic       sync_ack_o,
    output logic       sync_err_o,

    output logic [1:0] err_code_o,
    output logic       busy_o,

    output logic       cnt_enable_o,
    output logic       cnt_en_preset_o,
    output rtc_time_t  cnt_time_o,
    output logic       cnt_mode12_o,
    input  rtc_time_t  cur_time_i
);

    state_t     state;
    state_t     state_nxt;

    // Request register: what was granted, for whom.
    logic       req_op;
    rtc_time_t  req_time;
    logic       owner_sync;

    // Round-robin memory: 1 when sync was served last. Resets to 1 so that
    // host wins the first contested grant.
    logic       last_sync;

    logic       take;
    logic       take_sync;
    logic       fields_valid;
    logic       readback_ok;
    rtc_time_t  expect_time;

    logic       done_ok;
    logic       done_err;
    logic [1:0] err_sel;

    // Next values of the registered outputs.
    logic       busy_nxt;
    logic       en_nxt;
    logic       pre_nxt;
    rtc_time_t  time_nxt;
    logic [1:0] code_nxt;

    rtc_time_validator #(
        .YEAR_MIN (YEAR_MIN),
        .YEAR_MAX (YEAR_MAX)
    ) u_validator (
        .tm    (req_time),
        .valid (fields_valid)
    );

    // Readback target: the latched preset, or the default instant in the
    // format the counter is currently configured for.
    always_comb begin
        if (!req_op) begin
            expect_time = req_time;
        end else if (cnt_mode12_o) begin
            expect_time = DEFAULT_TIME_12;
        end else begin
            expect_time = DEFAULT_TIME_24;
        end
        readback_ok = (cur_time_i == expect_time);
    end

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk_1Hz_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Next state, grant and completion decode
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        err_sel   = ERR_NONE;
        // Sync wins when it is alone, or when both ask and host went last.
        take_sync = sync_req_i && (!host_req_i || !last_sync);

        case (state)
            IDLE: begin
                if (host_req_i || sync_req_i) begin
                    take      = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (req_op || fields_valid) begin
                    state_nxt = LOAD;
                end else begin
                    done_err  = 1'b1;
                    err_sel   = ERR_FIELD;
                    state_nxt = DONE;
                end
            end
            LOAD: begin
                state_nxt = CONFIRM;
            end
            CONFIRM: begin
                state_nxt = DONE;
                if (readback_ok) begin
                    done_ok  = 1'b1;
                end else begin
                    done_err = 1'b1;
                    err_sel  = ERR_READBACK;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one
    // is high exactly during the state it belongs to.
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        en_nxt   = (state_nxt == LOAD);
        pre_nxt  = en_nxt && !req_op;
        time_nxt = pre_nxt ? req_time : '0;
        code_nxt = done_err ? err_sel : ERR_NONE;
    end

    // ---------------------------------------------------------------
    // Request capture (IDLE -> CHECK)
    // ---------------------------------------------------------------
    always_ff @(posedge clk_1Hz_i) begin
        if (take) begin
            req_op   <= take_sync ? sync_op_i   : host_op_i;
            req_time <= take_sync ? sync_time_i : host_time_i;
        end
    end

    // ---------------------------------------------------------------
    // Grant ownership and round-robin history
    // ---------------------------------------------------------------
    always_ff @(posedge clk_1Hz_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_sync <= 1'b0;
            last_sync  <= 1'b1;
        end else begin
            if (take) begin
                owner_sync <= take_sync;
            end
            if (state == DONE) begin
                last_sync <= owner_sync;
            end
        end
    end

    // ---------------------------------------------------------------
    // Registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk_1Hz_i or negedge rstn_i) begin
        if (!rstn_i) begin
            busy_o          <= 1'b0;
            cnt_enable_o    <= 1'b0;
            cnt_en_preset_o <= 1'b0;
            cnt_time_o      <= '0;
            host_ack_o      <= 1'b0;
            host_err_o      <= 1'b0;
            sync_ack_o      <= 1'b0;
            sync_err_o      <= 1'b0;
            err_code_o      <= ERR_NONE;
            cnt_mode12_o    <= 1'b0;
        end else begin
            busy_o          <= busy_nxt;
            cnt_enable_o    <= en_nxt;
            cnt_en_preset_o <= pre_nxt;
            cnt_time_o      <= time_nxt;
            host_ack_o      <= done_ok  && !owner_sync;
            host_err_o      <= done_err && !owner_sync;
            sync_ack_o      <= done_ok  &&  owner_sync;
            sync_err_o      <= done_err &&  owner_sync;
            err_code_o      <= code_nxt;
            // Format select follows only a confirmed preset; a restore
            // keeps whatever format was configured before.
            if ((state == CONFIRM) && readback_ok && !req_op) begin
                cnt_mode12_o <= req_time.mode[0];
            end
        end
    end

endmodule

// File: tb/tb_rtc_preset_ctrl.sv
module tb_rtc_preset_ctrl;
    import rtc_pkg::*;

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic       host_req = 1'b0, sync_req = 1'b0;
    logic       host_op  = 1'b0, sync_op  = 1'b0;
    rtc_time_t  host_time = '0, sync_time = '0;
    logic       host_ack, host_err, sync_ack, sync_err;
    logic [1:0] err_code;
    logic       busy, en, pre, mode12;
    rtc_time_t  cnt_time;
    rtc_time_t  cur_time;
    rtc_time_t  cnt_q = '0;
    logic       corrupt = 1'b0;
    logic       chk_on  = 1'b0;
    int         cyc = 0;

    int n_chk = 0, n_pass = 0;

    // Events observed on the DUT outputs (written by the monitor only).
    int host_done_cnt = 0, sync_done_cnt = 0, en_cnt = 0;
    int host_ack_cyc = -1, host_err_cyc = -1, sync_ack_cyc = -1, sync_err_cyc = -1;
    int en_cyc = -1;
    logic [1:0] last_code = 2'b00;
    // Owned by the driver.
    int host_seen = 0, sync_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_preset_ctrl dut (
        .clk_1Hz_i       (clk),
        .rstn_i          (rstn),
        .host_req_i      (host_req),
        .host_op_i       (host_op),
        .host_time_i     (host_time),
        .host_ack_o      (host_ack),
        .host_err_o      (host_err),
        .sync_req_i      (sync_req),
        .sync_op_i       (sync_op),
        .sync_time_i     (sync_time),
        .sync_ack_o      (sync_ack),
        .sync_err_o      (sync_err),
        .err_code_o      (err_code),
        .busy_o          (busy),
        .cnt_enable_o    (en),
        .cnt_en_preset_o (pre),
        .cnt_time_o      (cnt_time),
        .cnt_mode12_o    (mode12),
        .cur_time_i      (cur_time)
    );

    function automatic rtc_time_t mk(input int s, input int mi, input int h, input int md,
                                     input int dw, input int dm, input int mo, input int y);
        rtc_time_t t;
        t.sec = 6'(s); t.min = 6'(mi); t.hour = 6'(h); t.mode = 2'(md);
        t.dow = 3'(dw); t.dom = 5'(dm); t.month = 4'(mo); t.year = 12'(y);
        return t;
    endfunction

    // Simple time counter: loads on the strobe, otherwise holds.
    always @(posedge clk) begin
        if (en) cnt_q <= pre ? cnt_time : (mode12 ? mk(0,0,12,1,1,1,1,2000) : mk(0,0,0,0,1,1,1,2000));
    end
    assign cur_time = corrupt ? rtc_time_t'(cnt_q ^ 44'h1) : cnt_q;

    // Calendar rules in plain arithmetic.
    function automatic bit tb_valid(input rtc_time_t t);
        int dim [13];
        int md;
        bit hour_ok;
        dim = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (t.month < 1 || t.month > 12) return 0;
        md = dim[t.month];
        if (t.month == 2 && (t.year % 4) == 0 && t.year != 2100) md = 29;
        if (t.mode[0]) hour_ok = (t.hour >= 1 && t.hour <= 12);
        else           hour_ok = (t.hour <= 23 && t.mode[1] == 1'b0);
        return (t.sec <= 59) && (t.min <= 59) && hour_ok && (t.dow >= 1) &&
               (t.dom >= 1) && (t.dom <= md) && (t.year >= 2000) && (t.year <= 2199);
    endfunction

    function automatic rtc_time_t gen_time();
        rtc_time_t t;
        int m12;
        if ($urandom_range(0, 9) < 3) begin
            t = rtc_time_t'({$urandom, $urandom_range(0, 4095)});
        end else begin
            m12 = $urandom_range(0, 1);
            t = mk($urandom_range(0, 59), $urandom_range(0, 59),
                   m12 ? $urandom_range(1, 12) : $urandom_range(0, 23), m12,
                   $urandom_range(1, 7),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(29, 31) : $urandom_range(1, 28),
                   $urandom_range(1, 12),
                   ($urandom_range(0, 7) == 0) ? $urandom_range(1990, 2210) : $urandom_range(2000, 2199));
        end
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // ---------------- Reference model (transaction level) ----------------
    typedef struct packed {
        logic busy, en, pre;
        rtc_time_t t;
        logic hack, herr, sack, serr;
        logic [1:0] code;
        logic m12;
    } ovec_t;

    ovec_t exp_q[$];
    ovec_t cur_exp = '0;
    int    m_last  = 1;      // 0 = host served last, 1 = sync served last
    logic  m_m12   = 1'b0;

    // A granted command produces a fixed cycle-by-cycle list of outputs.
    task automatic plan();
        bit ps;
        logic op;
        rtc_time_t t;
        ovec_t v;
        if (host_req && sync_req) ps = (m_last == 0);
        else                      ps = sync_req;
        op = ps ? sync_op : host_op;
        t  = ps ? sync_time : host_time;
        m_last = ps ? 1 : 0;
        v = '0; v.busy = 1'b1; v.m12 = m_m12;
        exp_q.push_back(v);
        if (!op && !tb_valid(t)) begin
            v.code = 2'b01;
            if (ps) v.serr = 1'b1; else v.herr = 1'b1;
            exp_q.push_back(v);
        end else begin
            v.en = 1'b1; v.pre = !op; v.t = op ? rtc_time_t'('0) : t;
            exp_q.push_back(v);
            v.en = 1'b0; v.pre = 1'b0; v.t = '0;
            exp_q.push_back(v);
            if (!corrupt) begin
                if (!op) m_m12 = t.mode[0];
                v.m12 = m_m12;
                if (ps) v.sack = 1'b1; else v.hack = 1'b1;
            end else begin
                v.code = 2'b10;
                if (ps) v.serr = 1'b1; else v.herr = 1'b1;
            end
            exp_q.push_back(v);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            exp_q.delete();
            cur_exp = '0;
            m_last  = 1;
            m_m12   = 1'b0;
        end else if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
        end else if (!cur_exp.busy && (host_req || sync_req)) begin
            plan();
            cur_exp = exp_q.pop_front();
        end else begin
            cur_exp = '0;
            cur_exp.m12 = m_m12;
        end
    end

    // ---------------- Compare / monitor ----------------
    initial forever begin
        ovec_t a;
        @(negedge clk);
        a.busy = busy; a.en = en; a.pre = pre; a.t = cnt_time;
        a.hack = host_ack; a.herr = host_err; a.sack = sync_ack; a.serr = sync_err;
        a.code = err_code; a.m12 = mode12;
        if (chk_on) check($sformatf("outputs cyc=%0d", cyc), 64'(a), 64'(cur_exp));
        if (host_ack) host_ack_cyc = cyc;
        if (host_err) host_err_cyc = cyc;
        if (sync_ack) sync_ack_cyc = cyc;
        if (sync_err) sync_err_cyc = cyc;
        if (host_ack || host_err) host_done_cnt++;
        if (sync_ack || sync_err) sync_done_cnt++;
        if (host_err || sync_err) last_code = err_code;
        if (en) begin en_cnt++; en_cyc = cyc; end
    end

    // ---------------- Driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (host_done_cnt != host_seen) begin host_seen = host_done_cnt; host_req = 1'b0; end
        if (sync_done_cnt != sync_seen) begin sync_seen = sync_done_cnt; sync_req = 1'b0; end
    endtask

    task automatic issue(input bit s, input logic op, input rtc_time_t t);
        if (s) begin sync_op = op; sync_time = t; sync_req = 1'b1; end
        else   begin host_op = op; host_time = t; host_req = 1'b1; end
    endtask

    task automatic wait_idle(input int maxc, input string name);
        for (int i = 0; i < maxc; i++) begin
            step();
            if (!host_req && !sync_req) return;
        end
        check({name, "_timeout"}, 64'd0, 64'd1);
        host_req = 1'b0;
        sync_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, en_before, done_before;
        bit seen;
        rtc_time_t t1;

        #2 rstn = 1'b0;
        #1 chk_on = 1'b1;

        // Pin the calendar model itself.
        check("pin_feb29_2024", 64'(tb_valid(mk(0,0,0,0,1,29,2,2024))), 64'd1);
        check("pin_feb29_2100", 64'(tb_valid(mk(0,0,0,0,1,29,2,2100))), 64'd0);
        check("pin_feb29_2000", 64'(tb_valid(mk(0,0,0,0,1,29,2,2000))), 64'd1);
        check("pin_apr31",      64'(tb_valid(mk(0,0,0,0,1,31,4,2050))), 64'd0);
        check("pin_12h_hour0",  64'(tb_valid(mk(0,0,0,1,1,1,1,2050))),  64'd0);
        check("pin_24h_mode2",  64'(tb_valid(mk(0,0,5,2,1,1,1,2050))),  64'd0);
        check("pin_year2200",   64'(tb_valid(mk(0,0,5,0,1,1,1,2200))),  64'd0);

        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_code", 64'(err_code), 64'd0);
        check("rst_time", 64'(cnt_time), 64'd0);
        check("rst_mode12", 64'(mode12), 64'd0);
        @(posedge clk); #1 rstn = 1'b1;

        // Both requesters from reset: host first, sync right after.
        step();
        issue(0, 1'b0, mk(10,20,5,0,2,10,3,2001));
        issue(1, 1'b0, mk(0,0,13,0,7,31,12,2199));
        k = cyc;
        wait_idle(40, "both");
        check("both_host_ack_cyc", 64'(host_ack_cyc), 64'(k + 4));
        check("both_sync_gap", 64'(sync_ack_cyc - host_ack_cyc), 64'd5);

        // Host preset 23:59:50, 24 h, dow 3, 28/02/2024.
        step();
        t1 = mk(50,59,23,0,3,28,2,2024);
        issue(0, 1'b0, t1);
        k = cyc;
        wait_idle(20, "t1");
        check("t1_load_cyc", 64'(en_cyc), 64'(k + 2));
        check("t1_ack_cyc", 64'(host_ack_cyc), 64'(k + 4));
        check("t1_counter", 64'(cur_time), 64'(t1));
        check("t1_mode12", 64'(mode12), 64'd0);

        // Sync preset 29/02/2100: rejected before any load.
        step();
        en_before = en_cnt;
        issue(1, 1'b0, mk(0,0,12,0,1,29,2,2100));
        k = cyc;
        wait_idle(20, "t2");
        check("t2_err_cyc", 64'(sync_err_cyc), 64'(k + 2));
        check("t2_code", 64'(last_code), 64'd1);
        check("t2_no_load", 64'(en_cnt), 64'(en_before));

        // Switch to 12 h, then restore default.
        step();
        issue(0, 1'b0, mk(0,30,7,1,5,15,6,2150));
        wait_idle(20, "t4a");
        check("t4_mode12_set", 64'(mode12), 64'd1);
        step();
        issue(0, 1'b1, gen_time());
        k = cyc;
        wait_idle(20, "t4b");
        check("t4_ack_cyc", 64'(host_ack_cyc), 64'(k + 4));
        check("t4_counter", 64'(cur_time), 64'(mk(0,0,12,1,1,1,1,2000)));
        check("t4_mode12_kept", 64'(mode12), 64'd1);

        // Readback mismatch.
        step();
        corrupt = 1'b1;
        issue(0, 1'b0, mk(1,2,3,0,4,5,6,2007));
        k = cyc;
        wait_idle(20, "t5");
        corrupt = 1'b0;
        check("t5_err_cyc", 64'(host_err_cyc), 64'(k + 4));
        check("t5_code", 64'(last_code), 64'd2);
        check("t5_mode12", 64'(mode12), 64'd1);

        // Reset during LOAD.
        step();
        issue(0, 1'b0, mk(9,9,9,0,2,2,2,2022));
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (en) seen = 1'b1;
        end
        check("t6_load_seen", 64'(seen), 64'd1);
        done_before = host_done_cnt;
        #1 rstn = 1'b0;
        host_req = 1'b0;
        #1;
        check("t6_en_async", 64'(en), 64'd0);
        repeat (2) @(negedge clk);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_mode12", 64'(mode12), 64'd0);
        @(posedge clk); #1 rstn = 1'b1;
        check("t6_no_ack", 64'(host_done_cnt), 64'(done_before));
        step();
        issue(0, 1'b0, mk(30,45,18,0,6,31,12,2199));
        k = cyc;
        wait_idle(20, "t6b");
        check("t6_next_ack", 64'(host_ack_cyc), 64'(k + 4));

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            step();
            if (!host_req && $urandom_range(0, 2) == 0)
                issue(0, ($urandom_range(0, 4) == 0), gen_time());
            if (!sync_req && $urandom_range(0, 2) == 0)
                issue(1, ($urandom_range(0, 4) == 0), gen_time());
            if (busy && host_req && $urandom_range(0, 3) == 0) host_time = gen_time();
            if (busy && sync_req && $urandom_range(0, 3) == 0) sync_time = gen_time();
        end
        wait_idle(60, "drain");
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rtc_preset_ctrl.md
# rtc_preset_ctrl

- Sequencer and arbiter that owns the preset/enable interface of the RTC time counter.
- Accepts set-time and restore-default commands from two requesters, the host register block and the external time-sync unit, and arbitrates between them round-robin.
- Validates calendar fields, drives the counter's load strobes, reads back the counter to confirm the load, and returns ack or err to the granted requester.
- Sits between the register/sync logic and the time counter in the 1 Hz domain.

## Interface
Parameters:
- YEAR_MIN, 2000: lowest accepted year.
- YEAR_MAX, 2199: highest accepted year.

Ports:
- clk_1Hz_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- host_req_i / sync_req_i  in  1  command request, level, held until ack/err
- host_op_i / sync_op_i  in  1  0 = preset from time bus, 1 = restore default
- host_time_i / sync_time_i  in  44  packed rtc_time_t: sec6, min6, hour6, mode2, dow3, dom5, month4, year12
- host_ack_o / sync_ack_o  out  1  one-cycle success pulse
- host_err_o / sync_err_o  out  1  one-cycle failure pulse
- err_code_o  out  2  01 invalid field, 10 readback mismatch; valid with any err pulse
- busy_o  out  1  high whenever state ≠ IDLE
- cnt_enable_o  out  1  counter enable strobe
- cnt_en_preset_o  out  1  counter preset select
- cnt_time_o  out  44  init values to the counter
- cnt_mode12_o  out  1  12-hour format select to the counter
- cur_time_i  in  44  live counter outputs, packed as rtc_time_t

## Operation
FSM states: IDLE, CHECK, LOAD, CONFIRM, DONE.
- IDLE
  - If any request is high, grant one, latch its op and time into an internal request register, and go to CHECK.
  - Arbitration is round-robin on a last-grant flop. Reset value of the flop favours host.
  - When both requests are high, the requester not served last wins.
- CHECK
  - Preset op: validate the latched time. Any failure goes to DONE with err_code 01; otherwise go to LOAD.
    - sec ≤ 59, min ≤ 59.
    - mode[0]=0: hour ≤ 23 and mode[1]=0. mode[0]=1: hour 1..12.
    - dow 1..7, month 1..12.
    - dom 1..max_day. max_day is 30 for months 4/6/9/11 and 31 for other non-February months. February is 29 if year%4==0 and year≠2100, else 28.
    - year YEAR_MIN..YEAR_MAX.
  - Default op: skip validation, go to LOAD.
- LOAD
  - cnt_enable_o=1.
  - Preset op: cnt_en_preset_o=1, cnt_time_o = latched time.
  - Default op: cnt_en_preset_o=0.
  - Next state is CONFIRM.
- CONFIRM
  - Compare cur_time_i against the expected value:
    - Preset op: the latched time.
    - Default op: 00:00:00, dow 1, dom 1, month 1, year 2000, with hour 0 / mode 00 if cnt_mode12_o=0, or hour 12 / mode 01 if cnt_mode12_o=1.
  - Match: DONE with ack. Mismatch: DONE with err, err_code 10.
- DONE
  - Pulse the granted requester's ack or err for exactly one cycle, then go to IDLE.
  - Update the last-grant flop.
- cnt_mode12_o is updated from mode[0] on an accepted preset (ack) only. A default op never changes it.

## Timing
- Reset values: state IDLE, all ack/err 0, err_code_o 00, busy_o 0, cnt_enable_o 0, cnt_en_preset_o 0, cnt_time_o 0, cnt_mode12_o 0, last-grant favours host.
- FSM outputs (enable/preset/time/ack/err/busy) are registered Moore decodes of state.
- Request sampled at the edge ending IDLE cycle k:
  - CHECK in k+1, LOAD in k+2.
  - The counter loads on the edge ending k+2.
  - CONFIRM in k+3 sees the loaded value; the counter advances only on the following edge.
  - ack in k+4.
- Invalid request: err in k+2.
- Requester drops req on the edge ending the DONE cycle. The IDLE cycle after DONE is therefore free for the other requester.
- Request dropped or time bus changed mid-operation: the latched copy is used and the operation completes with ack/err.
- A non-granted request stays pending with no ack.
- Reset asserted mid-operation: immediate return to IDLE, no ack/err emitted, cnt_enable_o drops asynchronously.

## Structure
- rtc_pkg holds:
  - typedef rtc_time_t (packed 44-bit struct)
  - typedef state_t
  - constants for the default time, the err codes, YEAR_MIN/YEAR_MAX defaults
  - function max_day(month, year)
- One sub-module: rtc_time_validator. It is combinational, takes rtc_time_t, and outputs valid. It is reused by the register block.

## Test plan
- Host preset 23:59:50, 24h, dow 3, 28/02/2024 → LOAD strobes in k+2; host_ack in k+4; cur_time_i shows 23:59:50; cnt_mode12_o=0.
- Sync preset dom 29, month 2, year 2100 → sync_err in k+2, err_code 01, no cnt_enable_o pulse.
- Both requests high from reset → host served first, sync immediately after; sync ack 5 cycles after host ack.
- Host default op with cnt_mode12_o=1 → counter reads 12:00:00, mode 01, 01/01/2000; host_ack.
- Force cur_time_i mismatch during CONFIRM → host_err, err_code 10, cnt_mode12_o unchanged.
- Assert rstn_i during LOAD → all outputs return to reset values; no ack; next request is served normally.
